// File: rtl/fft_chk_pkg.sv
// rtl/fft_chk_pkg.sv - shared types and widths for the FFT peak checker
// FFT_CHK_MAG_SQ_EN selects squared magnitude instead of |re|+|im|.
package fft_chk_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    EVAL,
    DONE
  } state_t;

`ifdef FFT_CHK_MAG_SQ_EN
  localparam bit MAG_SQ = 1'b1;
`else
  localparam bit MAG_SQ = 1'b0;
`endif

  function automatic int mag_width(input int dw);
    return MAG_SQ ? (2 * dw + 1) : (dw + 1);
  endfunction

  localparam int MAG_W = mag_width(16);

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/fft_chk_mag.sv
// rtl/fft_chk_mag.sv - one-stage magnitude component register with index/last sideband
// FFT_CHK_MAG_SQ_EN registers re^2 and im^2; otherwise |re| and |im|.
module fft_chk_mag
  import fft_chk_pkg::*;
#(
  parameter int DW = 16,
  parameter int IW = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DW-1:0]             re,
  input  logic [DW-1:0]             im,
  input  logic [IW-1:0]             idx,
  input  logic                      in_last,
  output logic                      out_valid,
  output logic [mag_width(DW)-2:0]  a,
  output logic [mag_width(DW)-2:0]  b,
  output logic [IW-1:0]             idx_q,
  output logic                      last_q
);

  localparam int CW = mag_width(DW) - 1;

  logic [CW-1:0] a_nx;
  logic [CW-1:0] b_nx;

`ifdef FFT_CHK_MAG_SQ_EN
  // Sign-extended operands: the low 2*DW product bits are the exact square.
  logic [2*DW-1:0] re_x;
  logic [2*DW-1:0] im_x;
  assign re_x = {{DW{re[DW-1]}}, re};
  assign im_x = {{DW{im[DW-1]}}, im};
  assign a_nx = re_x * re_x;
  assign b_nx = im_x * im_x;
`else
  // Unsigned DW-bit result holds 2^(DW-1) for the most negative input.
  assign a_nx = re[DW-1] ? (~re + 1'b1) : re;
  assign b_nx = im[DW-1] ? (~im + 1'b1) : im;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        a      <= a_nx;
        b      <= b_nx;
        idx_q  <= idx;
        last_q <= in_last;
      end
    end
  end

endmodule

// File: rtl/fft_peak_checker.sv
// rtl/fft_peak_checker.sv - per-frame FFT peak bin/length checker with LED verdict
// FFT_CHK_MAG_SQ_EN widens peak_mag to 2*DW+1 and uses re^2+im^2.
module fft_peak_checker
  import fft_chk_pkg::*;
#(
  parameter int DW        = 16,
  parameter int LOG2_N    = 8,
  parameter int EXP_BIN   = 5,
  parameter int FRAMES    = 4,
  parameter int BLINK_DIV = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [2*DW-1:0]          s_tdata,
  input  logic                     s_tlast,
  output logic [LOG2_N-1:0]        peak_bin,
  output logic [mag_width(DW)-1:0] peak_mag,
  output logic                     frame_done,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     err_len,
  output logic                     led
);

  localparam int IW = LOG2_N + 1;
  localparam int N  = 1 << LOG2_N;
  localparam int MW = mag_width(DW);
  localparam int CW = MW - 1;

  localparam logic [IW-1:0]     IDX_MAX  = '1;
  localparam logic [IW-1:0]     LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0]     FULL_IDX = IW'(N);
  localparam logic [LOG2_N-1:0] EXP_IDX  = LOG2_N'(EXP_BIN);
  localparam logic [CNT_W-1:0]  FRAMES_C = CNT_W'(FRAMES);

  state_t state, state_nx;

  logic [IW-1:0]        idx_cnt;
  logic                 drain_cnt;
  logic [CNT_W-1:0]     frames_seen;
  logic                 beat_in;
  logic                 load;

  logic                 s1_valid;
  logic [CW-1:0]        s1_a;
  logic [CW-1:0]        s1_b;
  logic [IW-1:0]        s1_idx;
  logic                 s1_last;
  logic [MW-1:0]        s1_mag;

  logic [MW-1:0]        max_mag;
  logic [LOG2_N-1:0]    max_idx;
  logic                 len_ok;
  logic                 frame_pass;

  logic [BLINK_DIV-1:0] blink_cnt;

  assign beat_in    = s_tvalid && (state == ACCUM);
  assign load       = (state == DRAIN) && drain_cnt;
  assign s1_mag     = MW'(s1_a) + MW'(s1_b);
  assign frame_pass = (max_idx == EXP_IDX) && len_ok;

  fft_chk_mag #(
    .DW (DW),
    .IW (IW)
  ) u_mag (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (beat_in),
    .re        (s_tdata[DW-1:0]),
    .im        (s_tdata[2*DW-1:DW]),
    .idx       (idx_cnt),
    .in_last   (s_tlast),
    .out_valid (s1_valid),
    .a         (s1_a),
    .b         (s1_b),
    .idx_q     (s1_idx),
    .last_q    (s1_last)
  );

  always_comb begin
    state_nx = state;
    s_tready = 1'b0;
    case (state)
      ACCUM: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) state_nx = EVAL;
      end
      EVAL: begin
        state_nx = (frames_seen >= FRAMES_C) ? DONE : ACCUM;
      end
      DONE: begin
        s_tready = 1'b1;
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Bin counter saturates so oversized frames can never alias back to N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_cnt <= '0;
    end else if (beat_in) begin
      if (s_tlast)                 idx_cnt <= '0;
      else if (idx_cnt != IDX_MAX) idx_cnt <= idx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_mag <= '0;
      max_idx <= '0;
      len_ok  <= 1'b0;
    end else if (state == EVAL) begin
      max_mag <= '0;
      max_idx <= '0;
      len_ok  <= 1'b0;
    end else if (s1_valid) begin
      if (s1_mag > max_mag) begin
        max_mag <= s1_mag;
        max_idx <= s1_idx[LOG2_N-1:0];
      end
      if (s1_last) len_ok <= (s1_idx == LAST_IDX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_len <= 1'b0;
    end else if ((beat_in && !s_tlast && (idx_cnt >= FULL_IDX)) ||
                 (s1_valid && s1_last && (s1_idx != LAST_IDX))) begin
      err_len <= 1'b1;
    end
  end

  // Verdict registers load on the DRAIN->EVAL edge so they are valid with frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done  <= 1'b0;
      peak_bin    <= '0;
      peak_mag    <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      frames_seen <= '0;
    end else begin
      frame_done <= load;
      if (load) begin
        peak_bin    <= max_idx;
        peak_mag    <= max_mag;
        frames_seen <= frames_seen + 1'b1;
        if (frame_pass) begin
          if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      led       <= 1'b0;
    end else if ((state == EVAL) && (state_nx == DONE)) begin
      blink_cnt <= '0;
      led       <= 1'b1;
    end else if (state == DONE) begin
      blink_cnt <= blink_cnt + 1'b1;
      if (fail_cnt == '0)      led <= 1'b1;
      else if (&blink_cnt)     led <= ~led;
    end
  end

endmodule
